// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: one-line 16-bit word buffer serving cart mapper ROM reads from the SDRAM port.
// Define CART_ROM_FETCH_PREFETCH_EN to add a shadow line that prefetches the next line after each fill.
module cart_rom_fetch #(
  parameter int ADDR_W     = 25,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pclk1,
  input  logic              pclk0,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic              cart_read,
  input  logic              flush,
  output logic [7:0]        rom_din,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              late
);
  localparam int WI_W  = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 1 - WI_W;
  localparam logic [WI_W-1:0] LAST_IDX = WI_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t                state;
  logic [15:0]           line_buf [LINE_WORDS];
  logic [TAG_W-1:0]      line_tag;
  logic                  line_valid;
  logic [LINE_WORDS-1:0] wr_mask;
  logic [ADDR_W-1:0]     req_addr;
  logic                  pending;
  logic [TAG_W-1:0]      fill_tag;
  logic [WI_W-1:0]       fill_idx;
  logic                  abort;

  logic [TAG_W-1:0]      req_tag;
  logic [WI_W-1:0]       req_idx;
  logic [WI_W-1:0]       next_idx;
  logic                  hit;
  logic                  same_fill;

`ifdef CART_ROM_FETCH_PREFETCH_EN
  logic [15:0]           sh_buf [LINE_WORDS];
  logic [TAG_W-1:0]      sh_tag;
  logic                  sh_valid;
  logic                  sh_hit;
  logic                  pf;
  logic                  pf_arm;
  assign sh_hit    = sh_valid && (sh_tag == req_tag);
  assign same_fill = !abort && !pf && (fill_tag == req_tag);
`else
  assign same_fill = !abort && (fill_tag == req_tag);
`endif

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[WI_W:1];
  assign next_idx = fill_idx + WI_W'(1);
  assign hit      = line_valid && (line_tag == req_tag);

  function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rom_din    <= 8'h00;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      late       <= 1'b0;
      line_valid <= 1'b0;
      line_tag   <= '0;
      wr_mask    <= '0;
      req_addr   <= '0;
      pending    <= 1'b0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      abort      <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_buf[i] <= 16'h0000;
`ifdef CART_ROM_FETCH_PREFETCH_EN
      for (int i = 0; i < LINE_WORDS; i++) sh_buf[i] <= 16'h0000;
      sh_tag   <= '0;
      sh_valid <= 1'b0;
      pf       <= 1'b0;
      pf_arm   <= 1'b0;
`endif
    end else begin
      // Requests arriving while a fill is running
      if (state != IDLE && pending) begin
`ifdef CART_ROM_FETCH_PREFETCH_EN
        if (pf) begin
          if (hit) begin
            rom_din <= pick(line_buf[req_idx], req_addr[0]);
            pending <= 1'b0;
          end else begin
            abort <= 1'b1;
          end
        end else
`endif
        if (same_fill && wr_mask[req_idx]) begin
          rom_din <= pick(line_buf[req_idx], req_addr[0]);
          pending <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          abort <= 1'b0;
          if (pending) begin
            if (hit) begin
              rom_din <= pick(line_buf[req_idx], req_addr[0]);
              pending <= 1'b0;
            end
`ifdef CART_ROM_FETCH_PREFETCH_EN
            else if (sh_hit) begin
              for (int i = 0; i < LINE_WORDS; i++) begin
                line_buf[i] <= sh_buf[i];
                sh_buf[i]   <= line_buf[i];
              end
              line_tag   <= sh_tag;
              sh_tag     <= line_tag;
              line_valid <= 1'b1;
              sh_valid   <= line_valid;
              rom_din    <= pick(sh_buf[req_idx], req_addr[0]);
              pending    <= 1'b0;
            end
`endif
            else begin
              state      <= REQ;
              busy       <= 1'b1;
              mem_req    <= 1'b1;
              mem_addr   <= {req_tag, {WI_W{1'b0}}};
              fill_tag   <= req_tag;
              fill_idx   <= '0;
              wr_mask    <= '0;
              line_tag   <= req_tag;
              line_valid <= 1'b0;
`ifdef CART_ROM_FETCH_PREFETCH_EN
              pf         <= 1'b0;
`endif
            end
          end
`ifdef CART_ROM_FETCH_PREFETCH_EN
          else if (pf_arm && line_valid) begin
            pf_arm <= 1'b0;
            if (!(sh_valid && sh_tag == line_tag + 1'b1)) begin
              state    <= REQ;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= {line_tag + 1'b1, {WI_W{1'b0}}};
              fill_tag <= line_tag + 1'b1;
              fill_idx <= '0;
              wr_mask  <= '0;
              sh_tag   <= line_tag + 1'b1;
              sh_valid <= 1'b0;
              pf       <= 1'b1;
            end
          end
`endif
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (abort) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state             <= GAP;
              wr_mask[fill_idx] <= 1'b1;
`ifdef CART_ROM_FETCH_PREFETCH_EN
              if (pf) sh_buf[fill_idx] <= mem_rdata;
              else
`endif
              line_buf[fill_idx] <= mem_rdata;
              // Critical word goes straight to the mapper
              if (pending && same_fill && fill_idx == req_idx) begin
                rom_din <= pick(mem_rdata, req_addr[0]);
                pending <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (fill_idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            state    <= REQ;
            fill_idx <= next_idx;
            mem_addr <= {fill_tag, next_idx};
            mem_req  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef CART_ROM_FETCH_PREFETCH_EN
          if (pf) begin
            sh_valid <= 1'b1;
          end else begin
            line_valid <= 1'b1;
            pf_arm     <= 1'b1;
          end
`else
          line_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase

      if (pclk0 && pending) late <= 1'b1;

      if (flush) begin
        line_valid <= 1'b0;
        wr_mask    <= '0;
        late       <= 1'b0;
        if (state != IDLE) abort <= 1'b1;
`ifdef CART_ROM_FETCH_PREFETCH_EN
        sh_valid <= 1'b0;
        pf_arm   <= 1'b0;
`endif
      end

      // A new sample overrides whatever request was outstanding
      if (pclk1 && cart_read) begin
        req_addr <= rom_address;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Directed bench for cart_rom_fetch: SDRAM responder with an expected-address queue and a
// scoreboard of expected rom_din bytes pushed at request time.
`timescale 1ns/1ps
module tb_cart_rom_fetch;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        pclk1 = 1'b0;
  logic        pclk0 = 1'b0;
  logic        cart_read = 1'b0;
  logic        flush = 1'b0;
  logic [24:0] rom_address = '0;
  logic [7:0]  rom_din;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic        late;

  int checks = 0;
  int errors = 0;
  int ack_delay = 2;
  int wait_cnt = 0;
  int req_cycles = 0;
  logic [23:0] addr_q[$];
  logic [7:0]  exp_q[$];

  always #5 clk_sys = ~clk_sys;

  cart_rom_fetch dut (
    .clk_sys(clk_sys), .reset(reset), .pclk1(pclk1), .pclk0(pclk0),
    .rom_address(rom_address), .cart_read(cart_read), .flush(flush),
    .rom_din(rom_din), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .late(late)
  );

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    if (a == 24'h004002) return 16'hBEEF;
    if (a == 24'h004000) return 16'h1234;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ a[7:0] ^ 8'hC3};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    logic [15:0] w;
    w = mem_word(a[24:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // SDRAM model: ack each request ack_delay+1 cycles after it appears
  always @(negedge clk_sys) begin
    mem_ack = 1'b0;
    if (reset || !mem_req) begin
      wait_cnt = 0;
    end else begin
      req_cycles++;
      wait_cnt++;
      if (wait_cnt > ack_delay) begin
        wait_cnt  = 0;
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_req observed %0h expected none", mem_addr);
        end else begin
          check("mem_addr", {8'h00, mem_addr}, {8'h00, addr_q.pop_front()});
        end
      end
    end
  end

  task automatic pulse(input logic [24:0] a);
    @(negedge clk_sys);
    rom_address = a;
    cart_read   = 1'b1;
    pclk1       = 1'b1;
    @(negedge clk_sys);
    pclk1     = 1'b0;
    cart_read = 1'b0;
  endtask

  task automatic issue(input logic [24:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    pulse(a);
  endtask

  task automatic expect_rom(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed %0h expected nothing queued", tag, rom_din);
    end else begin
      check(tag, {24'h0, rom_din}, {24'h0, exp_q.pop_front()});
    end
  endtask

  task automatic push_line(input logic [23:0] base);
    for (int i = 0; i < 4; i++) addr_q.push_back(base + 24'(i));
  endtask

  task automatic wait_ack(input string tag, input logic [23:0] a, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk_sys);
      #1;
      if (mem_ack && mem_addr == a) found = 1'b1;
    end
    check({tag, "_ack_seen"}, {31'h0, found}, 32'h1);
  endtask

  task automatic wait_req(input string tag, input logic [23:0] a, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk_sys);
      #1;
      if (mem_req && mem_addr == a) found = 1'b1;
    end
    check({tag, "_req_seen"}, {31'h0, found}, 32'h1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_sys);
      if (!busy) found = 1'b1;
    end
    check({tag, "_idle"}, {31'h0, found}, 32'h1);
  endtask

  task automatic do_flush();
    @(negedge clk_sys);
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
  endtask

  initial begin
    int snap;
    repeat (2) @(negedge clk_sys);
    check("rst_rom_din", {24'h0, rom_din}, 32'h00);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_late", {31'h0, late}, 32'h0);
    reset = 1'b0;

    // Cold miss, critical word is word 2 of line 0x4000
    push_line(24'h004000);
    issue(25'h0008005, 8'hBE);
    wait_ack("cold", 24'h004002, 60);
    @(negedge clk_sys);
    expect_rom("cold_rom_din");
    check("cold_busy", {31'h0, busy}, 32'h1);
    wait_idle("cold", 60);
    check("cold_late", {31'h0, late}, 32'h0);
    check("cold_addr_q", addr_q.size(), 32'h0);

    // Hits on the resident line
    snap = req_cycles;
    issue(25'h0008000, 8'h34);
    @(negedge clk_sys);
    expect_rom("hit0_rom_din");
    issue(25'h0008003, exp_byte(25'h0008003));
    @(negedge clk_sys);
    expect_rom("hit1_rom_din");
    check("hit_no_req", req_cycles, snap);

    // Deadline miss: pclk0 arrives long before the slow critical ack
    ack_delay = 8;
    push_line(24'h010000);
    issue(25'h0020002, exp_byte(25'h0020002));
    repeat (2) @(negedge clk_sys);
    pclk0 = 1'b1;
    @(negedge clk_sys);
    pclk0 = 1'b0;
    wait_ack("late", 24'h010001, 200);
    @(negedge clk_sys);
    expect_rom("late_rom_din");
    check("late_set", {31'h0, late}, 32'h1);
    wait_idle("late", 200);
    issue(25'h0020000, exp_byte(25'h0020000));
    @(negedge clk_sys);
    expect_rom("late_hit_rom_din");
    check("late_sticky", {31'h0, late}, 32'h1);
    do_flush();
    check("late_flush_clear", {31'h0, late}, 32'h0);
    ack_delay = 2;

    // Flush during the word-1 request, then full refetch from word 0
    addr_q.push_back(24'h004000);
    addr_q.push_back(24'h004001);
    push_line(24'h004000);
    issue(25'h0008005, 8'hBE);
    wait_req("flush", 24'h004001, 60);
    do_flush();
    wait_ack("flush_refetch", 24'h004002, 100);
    @(negedge clk_sys);
    expect_rom("flush_rom_din");
    wait_idle("flush", 60);
    check("flush_addr_q", addr_q.size(), 32'h0);

    // Different tags sampled during a fill: only the latest is queued
    push_line(24'h000000);
    push_line(24'h008000);
    issue(25'h0000001, exp_byte(25'h0000001));
    wait_ack("q_first", 24'h000000, 60);
    @(negedge clk_sys);
    expect_rom("q_first_rom_din");
    pulse(25'h0030000);
    issue(25'h0010000, exp_byte(25'h0010000));
    wait_ack("q_second", 24'h008000, 100);
    @(negedge clk_sys);
    expect_rom("q_second_rom_din");
    wait_idle("q", 60);
    check("q_addr_q", addr_q.size(), 32'h0);

    // Asynchronous reset while a request is outstanding
    ack_delay = 20;
    pulse(25'h0040000);
    wait_req("arst", 24'h020000, 20);
    #2 reset = 1'b1;
    #1;
    check("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check("arst_rom_din", {24'h0, rom_din}, 32'h00);
    check("arst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    ack_delay = 2;
    push_line(24'h004000);
    issue(25'h0008000, 8'h34);
    wait_ack("arst_miss", 24'h004000, 60);
    @(negedge clk_sys);
    expect_rom("arst_miss_rom_din");
    wait_idle("arst", 60);
    check("final_addr_q", addr_q.size(), 32'h0);
    check("final_exp_q", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
